// File: rtl/dmem_pkg.sv
// Shared sizes and types for the two-requester data-memory arbiter.
// Pure declarations: no latency, no flow control.
package dmem_pkg;
  localparam int AW = 8;
  localparam int DW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } state_t;

  typedef logic rid_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports, the memory port and busy.
// master = requesters plus memory, slave = arbiter; gnt is the only backpressure.
interface dmem_arbiter_if;
  import dmem_pkg::*;

  logic          r0_req;
  logic          r0_we;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r0_gnt;
  logic          r0_rvalid;
  logic [DW-1:0] r0_rdata;

  logic          r1_req;
  logic          r1_we;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic          r1_gnt;
  logic          r1_rvalid;
  logic [DW-1:0] r1_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata,
    input  busy
  );

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata,
    output busy
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; i_ptr names the requester favoured on a tie.
// Combinational, zero latency; a lone request always wins.
module rr_arbiter2
  import dmem_pkg::*;
(
  input  logic [1:0] i_req,
  input  rid_t       i_ptr,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = i_req;
    if (&i_req) o_gnt = i_ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between two requesters, one access at a time.
// gnt one cycle after the request is seen in IDLE; read data two cycles after gnt; busy stalls all requesters.
module dmem_arbiter
  import dmem_pkg::*;
(
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  state_t        r_state;
  state_t        w_next_state;
  rid_t          r_ptr;
  rid_t          r_owner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [1:0]    r_rvalid;
  logic [DW-1:0] r_rdata [2];

  logic [1:0]    w_req;
  logic [1:0]    w_pick;
  rid_t          w_win;
  logic          w_take;
  logic [1:0]    w_gnt;
  logic          w_mem_we;
  logic          w_mem_re;
  logic [DW-1:0] w_mem_wdata;

  assign w_req = {bus.r1_req, bus.r0_req};
  assign w_win = w_pick[1];

  rr_arbiter2 u_rr (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_take       = 1'b0;
    w_gnt        = 2'b00;
    w_mem_we     = 1'b0;
    w_mem_re     = 1'b0;
    w_mem_wdata  = '0;
    case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_take       = 1'b1;
          w_next_state = ISSUE;
        end
      end
      ISSUE: begin
        w_gnt[r_owner] = 1'b1;
        w_mem_we       = r_we;
        w_mem_re       = !r_we;
        w_mem_wdata    = r_we ? r_wdata : '0;
        w_next_state   = r_we ? IDLE : RDATA;
      end
      RDATA:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Latched request survives a dropped req; the pointer then favours the loser.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= 1'b0;
      r_owner    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rvalid   <= 2'b00;
      r_rdata[0] <= '0;
      r_rdata[1] <= '0;
    end else begin
      r_rvalid <= 2'b00;
      if (w_take) begin
        r_owner <= w_win;
        r_ptr   <= ~w_win;
        r_we    <= w_win ? bus.r1_we    : bus.r0_we;
        r_addr  <= w_win ? bus.r1_addr  : bus.r0_addr;
        r_wdata <= w_win ? bus.r1_wdata : bus.r0_wdata;
      end
      if (r_state == RDATA) begin
        r_rvalid[r_owner] <= 1'b1;
        r_rdata[r_owner]  <= bus.mem_rdata;
      end
    end
  end

  assign bus.r0_gnt    = w_gnt[0];
  assign bus.r1_gnt    = w_gnt[1];
  assign bus.r0_rvalid = r_rvalid[0];
  assign bus.r1_rvalid = r_rvalid[1];
  assign bus.r0_rdata  = r_rdata[0];
  assign bus.r1_rdata  = r_rdata[1];
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_re    = w_mem_re;
  assign bus.busy      = (r_state != IDLE);

endmodule
